// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct codes, multiply sequencer states and default operand width.
package alu_pkg;

  localparam int unsigned AluWidth = 32;

  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWb
  } multu_state_e;

  // Instructions that depend on the HI/LO unit and must wait for an in-flight multiply.
  function automatic logic is_hilo_op(input logic [5:0] funct);
    return (funct == FN_MULTU) || (funct == FN_MFHI) || (funct == FN_MFLO);
  endfunction

endpackage

// File: rtl/multu_step.sv
// One shift-add iteration: retires BITS_PER_CYCLE multiplier bits into the accumulator.
module multu_step #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0]   mplier_o
);

  // mcand_i is already aligned to the current iteration's bit offset.
  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_i[i]) begin
        acc_o = acc_o + (mcand_i << i);
      end
    end
  end

  assign mcand_o  = mcand_i << BITS_PER_CYCLE;
  assign mplier_o = mplier_i >> BITS_PER_CYCLE;

endmodule

// File: rtl/multu_sequencer.sv
// Iterative MULTU controller with HI/LO registers and EX-stage stall generation.
// Optional MULTU_EARLY_TERM_EN: finish as soon as the remaining multiplier is zero.
module multu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH          = AluWidth,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic [WIDTH-1:0] hilo_rdata
);

  localparam int unsigned NumIter = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW    = (NumIter > 1) ? $clog2(NumIter) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumIter - 1);

  multu_state_e      state_q;
  logic [CntW-1:0]   count_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]  mplier_q;

  logic [2*WIDTH-1:0] acc_nxt, mcand_nxt;
  logic [WIDTH-1:0]  mplier_nxt;
  logic              accept, run_last, accept_to_wb;

  multu_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_nxt),
    .mcand_o  (mcand_nxt),
    .mplier_o (mplier_nxt)
  );

  assign accept = issue_valid && (Funct == FN_MULTU) && (state_q == StIdle);
  assign stall  = issue_valid && (state_q != StIdle) && is_hilo_op(Funct);
  assign busy   = (state_q == StRun);

`ifdef MULTU_EARLY_TERM_EN
  // Once no multiplier bits remain, further iterations would add nothing.
  assign run_last     = (count_q == LastCnt) || (mplier_nxt == '0);
  assign accept_to_wb = (dataB == '0);
`else
  assign run_last     = (count_q == LastCnt);
  assign accept_to_wb = 1'b0;
`endif

  always_comb begin
    hilo_rdata = '0;
    if (issue_valid) begin
      if (Funct == FN_MFHI) begin
        hilo_rdata = HiOut;
      end else if (Funct == FN_MFLO) begin
        hilo_rdata = LoOut;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      HiOut    <= '0;
      LoOut    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, dataA};
            mplier_q <= dataB;
            count_q  <= '0;
            state_q  <= accept_to_wb ? StWb : StRun;
          end
        end
        StRun: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_nxt;
          mplier_q <= mplier_nxt;
          count_q  <= count_q + 1'b1;
          if (run_last) begin
            state_q <= StWb;
          end
        end
        StWb: begin
          HiOut   <= acc_q[2*WIDTH-1:WIDTH];
          LoOut   <= acc_q[WIDTH-1:0];
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/multu_sequencer.md
Name: multu_sequencer

Overview:
- Multi-cycle controller for the unsigned multiply path and the HI/LO registers in the EX stage.
- Accepts MULTU/MFHI/MFLO from the ALU control decode and runs an iterative shift-add multiply.
- Writes the 64-bit product into HI/LO and drives a pipeline stall when a HI/LO read or a second MULTU arrives while a multiply is still in flight.
- Replaces the single-step multiplier and HI/LO sequencing for the 5-stage pipeline.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH.
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration. Legal values: 1, 2, 4. Must divide WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  EX-stage R-type instruction present this cycle.
- Funct  in  6  function field: 011001 MULTU, 010000 MFHI, 010010 MFLO; all other codes are ignored.
- dataA  in  WIDTH  multiplicand (rs).
- dataB  in  WIDTH  multiplier (rt).
- stall  out  1  hold IF/ID/EX this cycle; combinational.
- busy  out  1  multiply in flight (state RUN).
- done  out  1  one-cycle pulse in the cycle after HI/LO are written.
- HiOut  out  WIDTH  HI register.
- LoOut  out  WIDTH  LO register.
- hilo_rdata  out  WIDTH  HiOut for MFHI, LoOut for MFLO, 0 otherwise; combinational.

Behaviour:
- Clocking: one clock domain. Reset is synchronous, active-high, and wins over every other input.
- Reset values: state=IDLE, HiOut=0, LoOut=0, busy=0, done=0, stall=0, iteration count=0.
- States:
  - IDLE: no multiply in flight.
  - RUN: iterating.
  - WB: HI/LO writeback cycle.
- Iteration count: N = WIDTH/BITS_PER_CYCLE (32 at defaults).
- A MULTU is accepted when issue_valid=1, Funct=MULTU, and state=IDLE.
  - At that edge, latch the multiplicand, the multiplier and a 2*WIDTH accumulator=0. Next state RUN, count=0.
- RUN, each edge:
  - Add the multiplicand times the low BITS_PER_CYCLE multiplier bits into the accumulator at the correct offset.
  - Shift the multiplier right, count++.
  - When count reaches N-1 at the edge, next state WB.
- WB edge: HiOut=acc[2W-1:W], LoOut=acc[W-1:0]; next state IDLE; done=1 for the following cycle only.
- Latency: accept edge E0, HI/LO valid after edge E(N+1). At defaults, written at E33 and visible in the cycle after.
- All arithmetic is unsigned, with no overflow. The product always fits in 2*WIDTH bits.
- stall=1 when issue_valid=1 and state is not IDLE and Funct is MULTU, MFHI or MFLO.
  - While stalled, the instruction is held upstream and re-presented every cycle.
  - It is accepted or read in the first cycle state=IDLE.
- MFHI/MFLO while IDLE: no stall; hilo_rdata reflects the current registers.
- In the cycle done=1 (state IDLE), reads see the new product.
- Back-to-back MULTU: the second stalls through RUN and WB and is accepted in the first IDLE cycle. HI/LO keep the first product until the second WB.
- issue_valid=0, or any other Funct: no effect, no stall.
- Reset mid-RUN: the multiply is aborted, HiOut/LoOut=0, done is not pulsed.
- Operands are sampled only at the accept edge; later changes to dataA/dataB are ignored.

Optional Feature:
- Macro: MULTU_EARLY_TERM_EN.
- Defined:
  - In RUN, if the remaining shifted multiplier is 0, go to WB at that edge. The accumulator is already final.
  - Accept with dataB=0 goes straight to WB on the next edge, for a 2-edge latency.
  - The stall rules are unchanged.
- Undefined: always exactly N RUN iterations, fixed latency N+1.

Decomposition:
- Shared package (alu_pkg):
  - Funct constants FN_MULTU, FN_MFHI, FN_MFLO.
  - State enum {IDLE, RUN, WB}.
  - WIDTH default.
- One natural sub-module: multu_step, a combinational partial-product add/shift for BITS_PER_CYCLE bits. The FSM, counter, HI/LO registers and stall logic stay in multu_sequencer.

Test Plan:
- Basic multiply: reset, then MULTU dataA=3, dataB=5. busy for cycles 1..32, done pulse at cycle 34, HiOut=0, LoOut=15, no stall.
- Max operands: MULTU 0xFFFFFFFF*0xFFFFFFFF -> HiOut=0xFFFFFFFE, LoOut=0x00000001.
- Read-after-multiply hazard: MULTU 0x10000*0x10000, then MFHI the next cycle. stall=1 for every cycle until IDLE, then hilo_rdata=0x00000001; MFLO then returns 0.
- Back-to-back MULTU: 2*3 followed by 7*9. The second stalls through the first RUN and WB; after the first done HI/LO=0/6, after the second done 0/63.
- Reset mid-op: reset at RUN count=10 -> next cycle IDLE, HiOut=LoOut=0, no done pulse; a new MULTU 4*4 gives LoOut=16.
- Early termination (MULTU_EARLY_TERM_EN defined): MULTU 0x12345678*1 -> done 3 cycles after accept, LoOut=0x12345678. With dataB=0, done follows WB on the next edge. Without the macro, the same stimulus takes the full N+1 latency.
